// File: rtl/approx_add_scheduler_pkg.sv
// ============================================================================
// Module   : approx_sched_pkg
// Brief    : Shared state encoding, width helpers and defaults for the
//            approximate-adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package approx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 32;
    localparam int DEF_ERRW = 48;

    function automatic int sched_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Requester IDs need at least one bit even for a degenerate single source
    function automatic int sched_idw(input int n);
        return (sched_clog2(n) < 1) ? 1 : sched_clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/approx_add_scheduler_if.sv
// ============================================================================
// Module   : approx_add_scheduler_if
// Brief    : Request, shared-adder and response bundle of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface approx_add_scheduler_if
    import approx_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) ();
    localparam int IDW = sched_idw(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W:0]        add_sum;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
    );

endinterface

`default_nettype wire

// File: rtl/approx_add_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or above ptr,
//            wrapping modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_any_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IDW'(idx);
            end
        end
        gnt_any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/approx_add_scheduler.sv
// ============================================================================
// Module   : approx_add_scheduler
// Brief    : Time-shares one external approximate adder among NREQ lanes;
//            optional error monitor under APPROX_ERR_MON_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_add_scheduler
    import approx_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
`ifdef APPROX_ERR_MON_EN
    ,
    parameter int ERRW = DEF_ERRW
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_add_scheduler_if.slave     bus
`ifdef APPROX_ERR_MON_EN
    ,
    input  logic                      err_clr_i,
    output logic [W:0]                err_max_o,
    output logic [ERRW-1:0]           err_sum_o,
    output logic [31:0]               err_cnt_o
`endif
);

    localparam int IDW = sched_idw(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q;
    logic [W-1:0]    op_a_q, op_b_q;
    logic [W-1:0]    sel_a, sel_b;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W:0]      rsp_sum_q;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            can_accept;
    logic            take;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // RESP with rsp_ready behaves like IDLE so back-to-back ops cost 2 cycles
    always_comb begin
        state_d    = state_q;
        can_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                can_accept = 1'b1;
                if (gnt_any) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    can_accept = 1'b1;
                    state_d    = gnt_any ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        take  = can_accept & gnt_any;
        ptr_d = ptr_q;
        if (take) ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = bus.req_a[i*W +: W];
                sel_b = bus.req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (take) begin
                op_a_q <= sel_a;
                op_b_q <= sel_b;
                id_q   <= gnt_idx;
            end
            if (state_q == ST_EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_sum_q   <= bus.add_sum;
                rsp_id_q    <= id_q;
            end else if (state_q == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (take && rst_n) ? gnt : '0;
    assign bus.add_a     = op_a_q;
    assign bus.add_b     = op_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef APPROX_ERR_MON_EN
    localparam int SUMW = ERRW + 1;

    logic [W:0]      err_max_q;
    logic [ERRW-1:0] err_sum_q;
    logic [31:0]     err_cnt_q;
    logic [W:0]      exact;
    logic [W:0]      ae;
    logic [SUMW-1:0] sum_ext;

    always_comb begin
        exact   = {1'b0, op_a_q} + {1'b0, op_b_q};
        ae      = (exact >= bus.add_sum) ? (exact - bus.add_sum) : (bus.add_sum - exact);
        sum_ext = {1'b0, err_sum_q} + SUMW'(ae);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_max_q <= '0;
            err_sum_q <= '0;
            err_cnt_q <= '0;
        end else if (err_clr_i) begin
            err_max_q <= '0;
            err_sum_q <= '0;
            err_cnt_q <= '0;
        end else if (state_q == ST_EXEC) begin
            if (ae > err_max_q) err_max_q <= ae;
            err_sum_q <= sum_ext[ERRW] ? '1 : sum_ext[ERRW-1:0];
            if (ae != '0 && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_max_o = err_max_q;
    assign err_sum_o = err_sum_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/approx_add_scheduler.md
Name: approx_add_scheduler

Overview:
Time-shares one external approximate W-bit adder (RCA32_TT3-class, purely combinational) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on requests and on the response.
- Operands are registered, so the shared adder sees stable inputs for a full cycle.
- Each sum is returned tagged with the requester ID.
- Sits between accelerator lanes and the approximate adder. An optional monitor tracks approximation error on-line.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand width; sum is W+1 bits
ERRW, 48, width of error-sum accumulator

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request i pending
req_a  in  NREQ*W  operand A; requester i at [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
req_ready  out  NREQ  one-hot accept strobe
add_a  out  W  to shared adder input A
add_b  out  W  to shared adder input B
add_sum  in  W+1  combinational result from shared adder
rsp_valid  out  1  response available
rsp_id  out  IDW  requester index (IDW = max(1, clog2(NREQ)))
rsp_sum  out  W+1  sampled add_sum
rsp_ready  in  1  consumer accepts response
busy  out  1  state != IDLE
err_clr, err_max(W+1), err_sum(ERRW), err_cnt(32): present only with the macro below

Behaviour:
- Reset (async, Rst_n=0) forces:
  - state=IDLE, rr pointer=0;
  - op_a/op_b/add_a/add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0;
  - req_ready=0, busy=0, monitor registers=0.
- Reset mid-operation discards the in-flight transaction; no response is produced.
- States:
  - IDLE: if any req_valid, grant g is the first set bit searching from ptr upward, wrapping mod NREQ.
    - req_ready[g]=1 combinationally in that cycle only.
    - On the clock edge: op_a<=req_a[g], op_b<=req_b[g], id<=g, ptr<=(g+1) mod NREQ, state->EXEC.
    - No req_valid: stay in IDLE.
  - EXEC: add_a=op_a, add_b=op_b (always driven from op regs).
    - On the edge: rsp_sum<=add_sum, rsp_id<=id, rsp_valid<=1, state->RESP.
    - req_ready=0.
  - RESP: rsp_valid=1, outputs held stable until rsp_ready.
    - rsp_ready=1 and a req_valid present: accept a new grant in the same cycle, exactly as in IDLE (req_ready one-hot); state->EXEC; rsp_valid drops next cycle.
    - rsp_ready=1 and no request: state->IDLE, rsp_valid<=0.
    - rsp_ready=0: stay in RESP, req_ready=0.
- Latency and throughput:
  - accept edge to rsp_valid = 2 cycles;
  - sustained throughput 1 op per 2 cycles with rsp_ready tied high.
- Requesters must hold req_a/req_b/req_valid until their req_ready is seen. Dropping req_valid before grant is legal; the request is lost.
- Fairness: with all requesters valid continuously, grants go 0,1,2,3,0,… Pointer wrap NREQ-1 -> 0.
- Arithmetic is unsigned; add_sum is W+1 bits. The consumer truncates to W bits for signed use.

Optional Feature:
APPROX_ERR_MON_EN
- With the macro: in EXEC, exact = op_a + op_b (W+1 bits) and ae = |exact - add_sum|. On the EXEC edge:
  - err_max <= max(err_max, ae);
  - err_sum += ae, saturating at all-ones;
  - err_cnt += (ae != 0), saturating.
  - err_clr (synchronous, level) zeroes all three and wins over a same-cycle update.
- Without the macro: no monitor logic and no err_* ports; behaviour otherwise identical.

Decomposition:
- Package approx_sched_pkg: state encoding (IDLE=0, EXEC=1, RESP=2, 2-bit), a clog2 function for IDW, default W/ERRW constants.
- One sub-module, rr_arbiter: NREQ-bit req vector and ptr in, one-hot grant plus grant index out; purely combinational. Pointer update stays in the parent.

Test Plan:
- Single request: req_valid=0001, a=5, b=7 -> req_ready=0001 for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=12.
- All four valid, rsp_ready=1, a_i=i, b_i=10:
  - grants in order 0,1,2,3,0;
  - sums 10,11,12,13;
  - one response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_sum/rsp_id stable, req_ready=0 throughout; release with a pending request -> accept on the same edge.
- Overflow: a=FFFFFFFF, b=1 -> rsp_sum=1_00000000 (33-bit).
- Rst_n pulsed low during EXEC -> rsp_valid never asserts, ptr=0, next grant goes to lowest valid index.
- APPROX_ERR_MON_EN with adder stub returning exact^1 for three ops:
  - err_cnt=3, err_max=1, err_sum=3;
  - err_clr asserted together with a 4th op's EXEC -> all 0.
